// File: rtl/pipe_stage_buf.sv
// Generic inter-stage pipeline register: PC + payload behind a 2-entry skid buffer
// with valid/ready handshake, flush with saturating discard count, and NOP on bubbles.
module pipe_stage_buf #(
  parameter int                 DATA_W  = 32,
  parameter int                 PC_W    = 32,
  parameter logic [DATA_W-1:0]  NOP_VAL = DATA_W'(32'h0000_0013),
  parameter int                 CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  drop_count
);

  logic [1:0]        count_reg, count_next;
  logic [PC_W-1:0]   head_pc_reg, head_pc_next, skid_pc_reg, skid_pc_next;
  logic [DATA_W-1:0] head_data_reg, head_data_next, skid_data_reg, skid_data_next;
  logic [CNT_W-1:0]  drop_count_reg, drop_count_next;
  logic [CNT_W+1:0]  drop_sum;
  logic              acc, emit;

  // Ready depends only on registered count, so no combinational path from out_ready.
  assign in_ready  = (count_reg != 2'd2) & ~stall & reset;
  assign out_valid = (count_reg != 2'd0) & ~stall & reset;
  assign acc       = in_valid & in_ready;
  assign emit      = out_valid & out_ready;

  assign out_pc     = out_valid ? head_pc_reg   : '0;
  assign out_data   = out_valid ? head_data_reg : NOP_VAL;
  assign occupancy  = count_reg;
  assign drop_count = drop_count_reg;

  assign drop_sum = {2'b00, drop_count_reg} + (CNT_W+2)'(count_reg) + (CNT_W+2)'(acc);

  always_comb begin
    count_next      = count_reg;
    head_pc_next    = head_pc_reg;
    head_data_next  = head_data_reg;
    skid_pc_next    = skid_pc_reg;
    skid_data_next  = skid_data_reg;
    drop_count_next = drop_count_reg;
    if (flush) begin
      count_next = 2'd0;
      if (drop_sum > {2'b00, {CNT_W{1'b1}}})
        drop_count_next = '1;
      else
        drop_count_next = drop_sum[CNT_W-1:0];
    end else if (!stall) begin
      if (acc && !emit) begin
        count_next = count_reg + 2'd1;
        if (count_reg == 2'd0) begin
          head_pc_next   = in_pc;
          head_data_next = in_data;
        end else begin
          skid_pc_next   = in_pc;
          skid_data_next = in_data;
        end
      end else if (emit && !acc) begin
        count_next     = count_reg - 2'd1;
        head_pc_next   = skid_pc_reg;
        head_data_next = skid_data_reg;
      end else if (acc && emit) begin
        if (count_reg == 2'd1) begin
          head_pc_next   = in_pc;
          head_data_next = in_data;
        end else begin
          head_pc_next   = skid_pc_reg;
          head_data_next = skid_data_reg;
          skid_pc_next   = in_pc;
          skid_data_next = in_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_reg      <= 2'd0;
      drop_count_reg <= '0;
    end else begin
      count_reg      <= count_next;
      drop_count_reg <= drop_count_next;
    end
  end

  // Payload storage carries no reset; contents are meaningless while count is 0.
  always_ff @(posedge clk) begin
    head_pc_reg   <= head_pc_next;
    head_data_reg <= head_data_next;
    skid_pc_reg   <= skid_pc_next;
    skid_data_reg <= skid_data_next;
  end

endmodule
